// File: rtl/accumulator_drain_sequencer_pkg.sv
// Shared types and helpers for the accumulator drain path.
//   drain_state_e : drain sequencer states
//   SHIFT_WIDTH   : width of the requantisation shift amount
//   run_max()     : largest zero-run value representable in a run field
package accumulator_drain_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        EMIT,
        DONE
    } drain_state_e;

    localparam int unsigned SHIFT_WIDTH = 5;

    function automatic int unsigned run_max(input int unsigned index_width);
        return (32'd1 << index_width) - 32'd1;
    endfunction

endpackage

// File: rtl/accumulator_drain_sequencer_if.sv
// Bus bundle between the drain sequencer, the accumulator banks and OARAM.
//   buf_read_en / buf_bank_read / buf_bank_entry : read request to the banks
//   buf_data_read                                 : signed data, one cycle after the request
//   out_valid / out_ready                         : output word handshake
//   out_value / out_zero_run / out_address        : output word payload
// master = drain sequencer side, slave = banks/OARAM side.
interface accumulator_drain_sequencer_if #(
    parameter int BANK_COUNT  = 32,
    parameter int TILE_SIZE   = 128,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int ADDR_WIDTH  = 10
);
    localparam int BANK_W  = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int ENTRY_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

    logic                   buf_read_en;
    logic [BANK_W-1:0]      buf_bank_read;
    logic [ENTRY_W-1:0]     buf_bank_entry;
    logic [ACC_WIDTH-1:0]   buf_data_read;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   out_value;
    logic [INDEX_WIDTH-1:0] out_zero_run;
    logic [ADDR_WIDTH-1:0]  out_address;

    modport master (
        output buf_read_en, buf_bank_read, buf_bank_entry,
        input  buf_data_read,
        output out_valid, out_value, out_zero_run, out_address,
        input  out_ready
    );

    modport slave (
        input  buf_read_en, buf_bank_read, buf_bank_entry,
        output buf_data_read,
        input  out_valid, out_value, out_zero_run, out_address,
        output out_ready
    );
endinterface

// File: rtl/accumulator_drain_sequencer_requant.sv
// Combinational requantisation of one accumulator word:
// ReLU, logical right shift, saturate to the unsigned output range.
//   acc_i   : signed accumulator word
//   shift_i : right-shift amount (shifts >= ACC_WIDTH give 0)
//   q_o     : unsigned requantised activation
module accumulator_drain_sequencer_requant
    import accumulator_drain_sequencer_pkg::*;
#(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0]   acc_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    output logic [OUT_WIDTH-1:0]   q_o
);
    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] shifted;

    always_comb begin
        mag     = acc_i[ACC_WIDTH-1] ? '0 : acc_i;
        shifted = mag >> shift_i;
        if (|shifted[ACC_WIDTH-1:OUT_WIDTH]) begin
            q_o = '1;
        end else begin
            q_o = shifted[OUT_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/accumulator_drain_sequencer.sv
// Drain engine for the accumulator banks. Walks every bank/entry bank-major,
// requantises each word and zero-run-length encodes the stream to OARAM.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : begin a drain (ignored while busy)
//   shift_amt      : requant shift, captured on accepted start
//   bus (master)   : bank read port and output word handshake
//   busy           : drain in progress (includes the done cycle)
//   done           : one-cycle end-of-drain pulse
//   emitted_count  : words emitted by the last drain, held until the next one ends
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read strobe for current bank/entry
// CHECK | read data valid; requantise and run-length decision
// EMIT  | output word valid, waiting for ready
// DONE  | end-of-drain pulse, publish count
module accumulator_drain_sequencer
    import accumulator_drain_sequencer_pkg::*;
#(
    parameter int BANK_COUNT  = 32,
    parameter int TILE_SIZE   = 128,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [SHIFT_WIDTH-1:0]  shift_amt,
    accumulator_drain_sequencer_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   emitted_count
);
    localparam int BANK_W  = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int ENTRY_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [BANK_W-1:0]      LAST_BANK  = BANK_W'(BANK_COUNT - 1);
    localparam logic [ENTRY_W-1:0]     LAST_ENTRY = ENTRY_W'(TILE_SIZE - 1);
    localparam logic [INDEX_WIDTH-1:0] RUN_MAX    = INDEX_WIDTH'(run_max(INDEX_WIDTH));

    drain_state_e           state_q;
    logic [BANK_W-1:0]      bank_q,  bank_d;
    logic [ENTRY_W-1:0]     entry_q, entry_d;
    logic [INDEX_WIDTH-1:0] run_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  count_q;
    logic [ADDR_WIDTH-1:0]  emitted_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   read_en_q;
    logic                   valid_q;
    logic [OUT_WIDTH-1:0]   value_q;
    logic [INDEX_WIDTH-1:0] zrun_q;

    logic [OUT_WIDTH-1:0]   q;
    logic                   is_last;

    accumulator_drain_sequencer_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
        .acc_i   (bus.buf_data_read),
        .shift_i (shift_q),
        .q_o     (q)
    );

    // Next traversal position: entry-minor, bank-major.
    always_comb begin
        is_last = (bank_q == LAST_BANK) && (entry_q == LAST_ENTRY);
        bank_d  = bank_q;
        entry_d = entry_q + ENTRY_W'(1);
        if (entry_q == LAST_ENTRY) begin
            entry_d = '0;
            bank_d  = bank_q + BANK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            entry_q   <= '0;
            run_q     <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            emitted_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_en_q <= 1'b0;
            valid_q   <= 1'b0;
            value_q   <= '0;
            zrun_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= shift_amt;
                        run_q     <= '0;
                        addr_q    <= '0;
                        count_q   <= '0;
                        bank_q    <= '0;
                        entry_q   <= '0;
                        busy_q    <= 1'b1;
                        read_en_q <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    read_en_q <= 1'b0;
                    state_q   <= CHECK;
                end
                CHECK: begin
                    if ((q == '0) && (run_q != RUN_MAX)) begin
                        run_q <= run_q + INDEX_WIDTH'(1);
                        if (is_last) begin
                            // A trailing zero run is never emitted.
                            emitted_q <= count_q;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            bank_q    <= bank_d;
                            entry_q   <= entry_d;
                            read_en_q <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end else begin
                        // Saturated run emits an explicit zero word carrying RUN_MAX.
                        value_q <= q;
                        zrun_q  <= run_q;
                        run_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        count_q <= count_q + ADDR_WIDTH'(1);
                        if (is_last) begin
                            emitted_q <= count_q + ADDR_WIDTH'(1);
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            bank_q    <= bank_d;
                            entry_q   <= entry_d;
                            read_en_q <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.buf_read_en    = read_en_q;
    assign bus.buf_bank_read  = bank_q;
    assign bus.buf_bank_entry = entry_q;
    assign bus.out_valid      = valid_q;
    assign bus.out_value      = value_q;
    assign bus.out_zero_run   = zrun_q;
    assign bus.out_address    = addr_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign emitted_count      = emitted_q;
endmodule

// File: tb/tb_accumulator_drain_sequencer.sv
module tb_accumulator_drain_sequencer;
    localparam int BC  = 2;
    localparam int TS  = 4;
    localparam int AW  = 24;
    localparam int OW  = 8;
    localparam int IW  = 2;
    localparam int ADW = 10;
    localparam int N   = BC * TS;
    localparam int RMAX = (1 << IW) - 1;
    localparam int OMAX = (1 << OW) - 1;

    typedef struct {
        int value;
        int run;
        int addr;
    } word_t;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [4:0]     shift_amt;
    logic           busy;
    logic           done;
    logic [ADW-1:0] emitted_count;

    accumulator_drain_sequencer_if #(
        .BANK_COUNT(BC), .TILE_SIZE(TS), .ACC_WIDTH(AW),
        .OUT_WIDTH(OW), .INDEX_WIDTH(IW), .ADDR_WIDTH(ADW)
    ) bus ();

    accumulator_drain_sequencer #(
        .BANK_COUNT(BC), .TILE_SIZE(TS), .ACC_WIDTH(AW),
        .OUT_WIDTH(OW), .INDEX_WIDTH(IW), .ADDR_WIDTH(ADW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .shift_amt     (shift_amt),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .emitted_count (emitted_count)
    );

    int    total = 0;
    int    bad   = 0;
    int    mem [N];
    word_t exp_q [$];
    int    exp_count;
    int    ready_mode = 0;
    bit    hold_data = 0;
    word_t popped;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference requantisation: ReLU, shift, clamp.
    function automatic int requant_m(input int acc, input int sh);
        int v;
        if (acc < 0 || sh >= AW) return 0;
        v = acc >>> sh;
        return (v > OMAX) ? OMAX : v;
    endfunction

    // Expected word list for the current memory image and shift.
    task automatic build_model(input int sh);
        int run;
        int addr;
        int q;
        word_t w;
        exp_q.delete();
        run  = 0;
        addr = 0;
        for (int i = 0; i < N; i++) begin
            q = requant_m(mem[i], sh);
            if (q == 0 && run < RMAX) begin
                run++;
            end else begin
                w.value = q;
                w.run   = run;
                w.addr  = addr % (1 << ADW);
                exp_q.push_back(w);
                addr++;
                run = 0;
            end
        end
        exp_count = exp_q.size();
    endtask

    task automatic gen_mem();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: mem[i] = 0;
                1: mem[i] = -int'($urandom_range(1, 5000));
                2: mem[i] = int'($urandom_range(1, 2000));
                default: mem[i] = int'($urandom_range(0, 8388607));
            endcase
        end
    endtask

    // Bank model: data for a strobe appears at the strobe cycle's negedge and
    // holds through the following cycle; otherwise junk.
    initial begin
        bus.buf_data_read = '0;
        forever begin
            @(negedge clk);
            if (bus.buf_read_en) begin
                bus.buf_data_read = AW'(mem[int'(bus.buf_bank_read) * TS + int'(bus.buf_bank_entry)]);
                hold_data = 1'b1;
            end else if (hold_data) begin
                hold_data = 1'b0;
            end else begin
                bus.buf_data_read = AW'($urandom);
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output word checker against the model's expected stream.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid) begin
            check("read_en_in_emit", 32'(bus.buf_read_en), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word_unexpected: got value %0d run %0d addr %0d expected no word",
                         bus.out_value, bus.out_zero_run, bus.out_address);
            end else begin
                check("out_value",    32'(bus.out_value),    exp_q[0].value);
                check("out_zero_run", 32'(bus.out_zero_run), exp_q[0].run);
                check("out_address",  32'(bus.out_address),  exp_q[0].addr);
                if (bus.out_ready) popped = exp_q.pop_front();
            end
        end
    end

    task automatic start_pulse(input int sh);
        @(posedge clk);
        #1;
        start     = 1'b1;
        shift_amt = 5'(sh);
        @(posedge clk);
        #1;
        start     = 1'b0;
        shift_amt = 5'($urandom_range(0, 31));
        check("busy_after_start", 32'(busy), 1);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            check("emitted_count", 32'(emitted_count), exp_count);
            check("words_left", 32'(exp_q.size()), 0);
        end
        exp_q.delete();
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        @(negedge clk);
        check("emitted_count_held", 32'(emitted_count), exp_count);
    endtask

    task automatic run_drain(input int sh, input int rmode, input bit poke);
        build_model(sh);
        ready_mode = rmode;
        start_pulse(sh);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            start     = 1'b1;
            shift_amt = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
        after_done();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_en"},  32'(bus.buf_read_en),    0);
        check({tag, "_bank"},     32'(bus.buf_bank_read),  0);
        check({tag, "_entry"},    32'(bus.buf_bank_entry), 0);
        check({tag, "_valid"},    32'(bus.out_valid),      0);
        check({tag, "_value"},    32'(bus.out_value),      0);
        check({tag, "_run"},      32'(bus.out_zero_run),   0);
        check({tag, "_addr"},     32'(bus.out_address),    0);
        check({tag, "_busy"},     32'(busy),               0);
        check({tag, "_done"},     32'(done),               0);
        check({tag, "_count"},    32'(emitted_count),      0);
    endtask

    int sh;

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        shift_amt = '0;
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // All entries 5, shift 0.
        for (int i = 0; i < N; i++) mem[i] = 5;
        build_model(0);
        check("pin1_count", exp_count, 8);
        check("pin1_last_addr", exp_q[7].addr, 7);
        run_drain(0, 0, 1'b0);
        check("t1_emitted_literal", 32'(emitted_count), 8);

        // Zero runs, including a saturated run.
        mem = '{0, 0, 7, 0, 0, 0, 0, 9};
        build_model(0);
        check("pin2_count", exp_count, 3);
        check("pin2_w0_value", exp_q[0].value, 7);
        check("pin2_w0_run",   exp_q[0].run,   2);
        check("pin2_w1_value", exp_q[1].value, 0);
        check("pin2_w1_run",   exp_q[1].run,   3);
        check("pin2_w2_value", exp_q[2].value, 9);
        run_drain(0, 0, 1'b0);

        // ReLU, saturation and trailing zeros with shift 2.
        mem = '{-4, 300, 1024, 0, 0, 0, 0, 0};
        build_model(2);
        check("pin3_count", exp_count, 3);
        check("pin3_w0_value", exp_q[0].value, 75);
        check("pin3_w0_run",   exp_q[0].run,   1);
        check("pin3_w1_value", exp_q[1].value, 255);
        check("pin3_w2_run",   exp_q[2].run,   3);
        run_drain(2, 1, 1'b0);

        // Ready held low for 10 cycles on the first word.
        mem = '{0, 3, 0, 0, 6, 0, 0, 0};
        build_model(0);
        ready_mode = 2;
        start_pulse(0);
        begin
            bit got_valid;
            got_valid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    got_valid = 1'b1;
                    break;
                end
            end
            check("stall_valid_seen", 32'(got_valid), 1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_read_en", 32'(bus.buf_read_en), 0);
        end
        ready_mode = 0;
        wait_done();
        after_done();

        // Start pulsed while busy.
        gen_mem();
        run_drain(3, 1, 1'b1);

        // Start held through the done cycle: ignored there, taken next cycle.
        gen_mem();
        build_model(1);
        ready_mode = 0;
        start_pulse(1);
        wait_done();
        gen_mem();
        sh = 4;
        build_model(sh);
        start     = 1'b1;
        shift_amt = 5'(sh);
        @(posedge clk);
        #1;
        check("start_in_done_busy", 32'(busy), 0);
        check("start_in_done_done", 32'(done), 0);
        @(posedge clk);
        #1;
        check("start_after_done_busy", 32'(busy), 1);
        start     = 1'b0;
        shift_amt = 5'($urandom_range(0, 31));
        wait_done();
        after_done();

        // Reset in the middle of a drain, then a fresh drain.
        gen_mem();
        build_model(2);
        ready_mode = 1;
        start_pulse(2);
        repeat (7) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        gen_mem();
        run_drain(1, 1, 1'b0);

        // Randomised drains.
        for (int k = 0; k < 10; k++) begin
            gen_mem();
            sh = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 10));
            run_drain(sh, (k % 3 == 0) ? 0 : 1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
